// File: rtl/nn_layer_sequencer.sv
// rtl/nn_layer_sequencer.sv - loads one input sample, fires each start/done layer in order, presents the result
module nn_layer_sequencer #(
  parameter int NUM_LAYERS = 2,
  parameter int NUM_IN     = 1,
  parameter int OUT_W      = 8,
  parameter int TIMEOUT    = 63
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [NUM_IN*8-1:0]   x_out,
  output logic [NUM_LAYERS-1:0] layer_start,
  input  logic [NUM_LAYERS-1:0] layer_done,
  input  logic [OUT_W-1:0]      y_in,
  output logic [OUT_W-1:0]      y_data,
  output logic                  y_valid,
  input  logic                  y_ready,
  output logic                  busy,
  output logic                  err
);

  localparam int CW = $clog2(NUM_IN + 1);
  localparam int IW = $clog2(NUM_LAYERS + 1);

  typedef enum logic [1:0] {S_LOAD, S_START, S_WAIT, S_OUTPUT} state_t;

  state_t                  state;
  state_t                  state_next;
  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [7:0]              tmo;
  logic [NUM_LAYERS-1:0]   idx_onehot;
  logic                    done_sel;
  logic                    last_byte;
  logic                    last_layer;
  logic                    tmo_hit;

  // Only the done bit of the layer currently being waited on matters.
  assign idx_onehot = NUM_LAYERS'(1) << idx;
  assign done_sel   = |(layer_done & idx_onehot);
  assign last_byte  = in_valid && (cnt == CW'(NUM_IN - 1));
  assign last_layer = (idx == IW'(NUM_LAYERS - 1));
  assign tmo_hit    = ({1'b0, tmo} + 9'd1) >= 9'(TIMEOUT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_LOAD;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_LOAD:   if (last_byte) state_next = S_START;
      S_START:  state_next = S_WAIT;
      S_WAIT: begin
        if (done_sel)     state_next = last_layer ? S_OUTPUT : S_START;
        else if (tmo_hit) state_next = S_LOAD;
      end
      S_OUTPUT: if (y_ready) state_next = S_LOAD;
      default:  state_next = S_LOAD;
    endcase
  end

  always_comb begin
    in_ready    = (state == S_LOAD);
    busy        = (state != S_LOAD);
    y_valid     = (state == S_OUTPUT);
    layer_start = (state == S_START) ? idx_onehot : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_out  <= '0;
      cnt    <= '0;
      idx    <= '0;
      tmo    <= '0;
      y_data <= '0;
      err    <= 1'b0;
    end else begin
      case (state)
        S_LOAD: begin
          if (in_valid) begin
            for (int k = 0; k < NUM_IN; k++)
              if (cnt == CW'(k)) x_out[8*k +: 8] <= in_data;
            cnt <= last_byte ? '0 : cnt + CW'(1);
            if (last_byte) idx <= '0;
          end
        end
        S_START: tmo <= '0;
        S_WAIT: begin
          // A done seen on the final counted cycle still wins over the timeout.
          if (done_sel) begin
            if (last_layer) y_data <= y_in;
            else            idx    <= idx + IW'(1);
          end else begin
            if (tmo != 8'hFF) tmo <= tmo + 8'd1;
            if (tmo_hit) begin
              err <= 1'b1;
              idx <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// tb/tb_nn_layer_sequencer.sv - randomized self-checking bench for nn_layer_sequencer
module tb_nn_layer_sequencer;

  localparam int NL  = 2;
  localparam int NI  = 2;
  localparam int OW  = 8;
  localparam int TMO = 63;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [7:0]      in_data = '0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [NI*8-1:0] x_out;
  logic [NL-1:0]   layer_start;
  logic [NL-1:0]   layer_done = '0;
  logic [OW-1:0]   y_in = '0;
  logic [OW-1:0]   y_data;
  logic            y_valid;
  logic            y_ready = 1'b0;
  logic            busy;
  logic            err;

  int              tests = 0;
  int              fails = 0;
  bit              err_exp = 0;
  int              dly [NL];
  int              rem [NL];
  logic [NL-1:0]   starts [$];

  nn_layer_sequencer #(.NUM_LAYERS(NL), .NUM_IN(NI), .OUT_W(OW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .x_out(x_out), .layer_start(layer_start), .layer_done(layer_done), .y_in(y_in),
    .y_data(y_data), .y_valid(y_valid), .y_ready(y_ready), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Layer model: done level rises dly[i] cycles after the start pulse and stays high until the next start.
  initial for (int i = 0; i < NL; i++) begin rem[i] = 0; dly[i] = 1; end
  always @(posedge clk) begin
    for (int i = 0; i < NL; i++) begin
      if (layer_start[i]) begin
        rem[i]        <= dly[i] - 1;
        layer_done[i] <= (dly[i] == 1);
      end else if (rem[i] > 0) begin
        rem[i] <= rem[i] - 1;
        if (rem[i] == 1) layer_done[i] <= 1'b1;
      end
    end
  end

  always @(negedge clk) if (layer_start != '0) starts.push_back(layer_start);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_x_out"}, x_out, 0);
    check({tag, "_layer_start"}, layer_start, 0);
    check({tag, "_y_data"}, y_data, 0);
    check({tag, "_y_valid"}, y_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_err"}, err, 0);
  endtask

  task automatic run_inf(input logic [7:0] b0, input logic [7:0] b1, input int gap,
                         input int d0, input int d1, input logic [7:0] yv,
                         input int hold, input bit junk);
    int n;
    int exp_n;
    bit ok;
    logic [NL-1:0] exp_starts [$];
    dly[0] = d0;
    dly[1] = d1;
    y_in   = yv;
    starts.delete();
    @(negedge clk);
    check("load_ready", in_ready, 1);
    check("load_busy", busy, 0);
    in_data = b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (gap) begin
      @(negedge clk);
      check("gap_no_start", starts.size(), 0);
      check("gap_ready", in_ready, 1);
    end
    in_data = b1; in_valid = 1'b1;
    n = 0;
    while (n < 400) begin
      @(negedge clk);
      n++;
      check("x_hold", x_out, {b1, b0});
      if (y_valid || in_ready) break;
      check("busy_run", busy, 1);
      in_valid = junk;
      in_data  = 8'($urandom);
    end
    in_valid = 1'b0;

    ok = 1; exp_n = 1;
    for (int i = 0; i < NL; i++) begin
      if (!ok) break;
      exp_starts.push_back(NL'(1) << i);
      if (dly[i] <= TMO) exp_n += 1 + dly[i];
      else begin ok = 0; exp_n += 1 + TMO; end
    end
    if (!ok) err_exp = 1;
    check("outcome_y_valid", y_valid, ok);
    check("latency", n, exp_n);
    check("err_flag", err, err_exp);
    check("start_count", starts.size(), exp_starts.size());
    for (int i = 0; i < exp_starts.size() && i < starts.size(); i++)
      check("start_order", starts[i], exp_starts[i]);

    if (ok) begin
      check("y_data", y_data, yv);
      repeat (hold) begin
        y_in = 8'($urandom);
        @(negedge clk);
        check("hold_valid", y_valid, 1);
        check("hold_y_data", y_data, yv);
        check("hold_in_ready", in_ready, 0);
      end
      y_ready = 1'b1;
      @(negedge clk);
      y_ready = 1'b0;
      check("post_valid", y_valid, 0);
      check("post_ready", in_ready, 1);
      check("post_busy", busy, 0);
    end else begin
      check("to_busy", busy, 0);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    run_inf(8'h05, 8'h00, 0, 16, 16, 8'h2A, 10, 1'b0);
    run_inf(8'h11, 8'h22, 3, 1, 1, 8'h5C, 0, 1'b0);
    run_inf(8'hA1, 8'hB2, 0, 5, 1000, 8'h33, 0, 1'b1);
    run_inf(8'hC3, 8'hD4, 1, 2, 3, 8'h44, 1, 1'b1);
    run_inf(8'h01, 8'h02, 0, TMO, 1, 8'h66, 0, 1'b0);
    run_inf(8'h03, 8'h04, 0, 1, TMO + 1, 8'h77, 0, 1'b0);
    run_inf(8'h07, 8'h08, 0, TMO + 1, 1, 8'h88, 0, 1'b1);

    for (int r = 0; r < 10; r++)
      run_inf(8'($urandom), 8'($urandom), $urandom_range(0, 3),
              $urandom_range(1, 20), $urandom_range(1, 20), 8'($urandom),
              $urandom_range(0, 3), 1'($urandom_range(0, 1)));

    dly[0] = 20; dly[1] = 20;
    @(negedge clk);
    in_data = 8'h9A; in_valid = 1'b1;
    @(negedge clk);
    in_data = 8'hBC;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 20 && !layer_start[0]; k++) @(negedge clk);
    check("rst_saw_start", layer_start, 2'b01);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    err_exp = 0;
    @(negedge clk);
    rst_n = 1'b1;
    run_inf(8'h5A, 8'hA5, 0, 4, 7, 8'h99, 2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
